tile_scheduler: RTL

TILE_SCHEDULER -- requirements
Module: tile_scheduler

---
 rtl/tile_sched_pkg.sv | 16 +
 rtl/tile_idx_counter.sv | 89 ++++++++
 rtl/tile_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tile_sched_pkg.sv
// Shared types and default geometry for the tile scheduler.
package tile_sched_pkg;

  localparam int DEF_IDX_W         = 8;
  localparam int DEF_ADDR_W        = 20;
  localparam int DEF_W_TILE_STRIDE = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

endpackage

// File: rtl/tile_idx_counter.sv
// Nested tile counter: K is the inner index, N the outer one; the
// acc_clear/last_k/last_tile flags are registered alongside the indices.
module tile_idx_counter
  import tile_sched_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [IDX_W-1:0] n_tiles,
  input  logic [IDX_W-1:0] k_tiles,
  output logic [IDX_W-1:0] n_idx,
  output logic [IDX_W-1:0] k_idx,
  output logic             acc_clear,
  output logic             last_k,
  output logic             last_tile
);

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  logic [IDX_W-1:0] n_lim_reg, n_lim_next;
  logic [IDX_W-1:0] k_lim_reg, k_lim_next;
  logic [IDX_W-1:0] n_idx_reg, n_idx_next;
  logic [IDX_W-1:0] k_idx_reg, k_idx_next;
  logic             acc_clear_reg, acc_clear_next;
  logic             last_k_reg, last_k_next;
  logic             last_n_reg, last_n_next;

  always_comb begin
    n_lim_next     = n_lim_reg;
    k_lim_next     = k_lim_reg;
    n_idx_next     = n_idx_reg;
    k_idx_next     = k_idx_reg;
    acc_clear_next = acc_clear_reg;
    last_k_next    = last_k_reg;
    last_n_next    = last_n_reg;
    if (load) begin
      n_lim_next     = n_tiles;
      k_lim_next     = k_tiles;
      n_idx_next     = '0;
      k_idx_next     = '0;
      acc_clear_next = 1'b1;
      last_k_next    = (k_tiles == ONE);
      last_n_next    = (n_tiles == ONE);
    end else if (step) begin
      if (last_k_reg) begin
        // K wraps: move to the next output-column tile
        k_idx_next     = '0;
        n_idx_next     = n_idx_reg + ONE;
        acc_clear_next = 1'b1;
        last_k_next    = (k_lim_reg == ONE);
        last_n_next    = ((n_idx_reg + ONE) == (n_lim_reg - ONE));
      end else begin
        k_idx_next     = k_idx_reg + ONE;
        acc_clear_next = 1'b0;
        last_k_next    = ((k_idx_reg + ONE) == (k_lim_reg - ONE));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lim_reg     <= '0;
      k_lim_reg     <= '0;
      n_idx_reg     <= '0;
      k_idx_reg     <= '0;
      acc_clear_reg <= 1'b0;
      last_k_reg    <= 1'b0;
      last_n_reg    <= 1'b0;
    end else begin
      n_lim_reg     <= n_lim_next;
      k_lim_reg     <= k_lim_next;
      n_idx_reg     <= n_idx_next;
      k_idx_reg     <= k_idx_next;
      acc_clear_reg <= acc_clear_next;
      last_k_reg    <= last_k_next;
      last_n_reg    <= last_n_next;
    end
  end

  assign n_idx     = n_idx_reg;
  assign k_idx     = k_idx_reg;
  assign acc_clear = acc_clear_reg;
  assign last_k    = last_k_reg;
  assign last_tile = last_k_reg & last_n_reg;

endmodule

// File: rtl/tile_scheduler.sv
// Layer tile scheduler driving global_controller one (n,k) tile at a time.
// Optional performance counters are enabled by defining TILE_SCHED_PERF_CNT_EN.
module tile_scheduler
  import tile_sched_pkg::*;
#(
  parameter int IDX_W         = DEF_IDX_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int W_TILE_STRIDE = DEF_W_TILE_STRIDE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sched_start,
  input  logic              sched_abort,
  input  logic [IDX_W-1:0]  cfg_n_tiles,
  input  logic [IDX_W-1:0]  cfg_k_tiles,
  input  logic [31:0]       cfg_seq_len,
  input  logic              ctrl_ap_idle,
  input  logic              ctrl_ap_done,
  output logic              tile_start,
  output logic [31:0]       tile_seq_len,
  output logic [IDX_W-1:0]  tile_n_idx,
  output logic [IDX_W-1:0]  tile_k_idx,
  output logic              tile_acc_clear,
  output logic              tile_last_k,
  output logic [ADDR_W-1:0] weight_base_addr,
  output logic              sched_busy,
  output logic              sched_done
`ifdef TILE_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]       perf_busy_cycles,
  output logic [31:0]       perf_wait_cycles
`endif
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(W_TILE_STRIDE);

  sched_state_e      state_reg, state_next;
  logic [31:0]       seq_len_reg;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              tile_start_reg, tile_start_next;
  logic              cnt_load;
  logic              cnt_step;
  logic              last_tile;
  logic              cfg_zero;

  assign cfg_zero = (cfg_n_tiles == '0) || (cfg_k_tiles == '0);

  tile_idx_counter #(
    .IDX_W(IDX_W)
  ) u_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .step     (cnt_step),
    .n_tiles  (cfg_n_tiles),
    .k_tiles  (cfg_k_tiles),
    .n_idx    (tile_n_idx),
    .k_idx    (tile_k_idx),
    .acc_clear(tile_acc_clear),
    .last_k   (tile_last_k),
    .last_tile(last_tile)
  );

  always_comb begin
    state_next      = state_reg;
    tile_start_next = 1'b0;
    cnt_load        = 1'b0;
    cnt_step        = 1'b0;
    addr_next       = addr_reg;
    if (sched_abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (sched_start) begin
            cnt_load   = 1'b1;
            addr_next  = '0;
            state_next = cfg_zero ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ctrl_ap_idle) begin
            tile_start_next = 1'b1;
            state_next      = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ctrl_ap_done) state_next = ST_NEXT;
        end
        ST_NEXT: begin
          // Indices park on the final tile rather than stepping past it
          if (last_tile) begin
            state_next = ST_DONE;
          end else begin
            cnt_step   = 1'b1;
            addr_next  = addr_reg + STRIDE;
            state_next = ST_ISSUE;
          end
        end
        ST_DONE:  state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      seq_len_reg    <= '0;
      addr_reg       <= '0;
      tile_start_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      tile_start_reg <= tile_start_next;
      if (cnt_load) seq_len_reg <= cfg_seq_len;
    end
  end

  assign tile_start       = tile_start_reg;
  assign tile_seq_len     = seq_len_reg;
  assign weight_base_addr = addr_reg;
  assign sched_busy       = (state_reg != ST_IDLE);
  assign sched_done       = (state_reg == ST_DONE);

`ifdef TILE_SCHED_PERF_CNT_EN
  logic [31:0] busy_cnt_reg;
  logic [31:0] wait_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt_reg <= '0;
      wait_cnt_reg <= '0;
    end else if (cnt_load) begin
      busy_cnt_reg <= '0;
      wait_cnt_reg <= '0;
    end else begin
      if ((state_reg != ST_IDLE) && (busy_cnt_reg != '1))
        busy_cnt_reg <= busy_cnt_reg + 32'd1;
      // Stall cycles: tile ready but the controller is still occupied
      if ((state_reg == ST_ISSUE) && !ctrl_ap_idle && (wait_cnt_reg != '1))
        wait_cnt_reg <= wait_cnt_reg + 32'd1;
    end
  end

  assign perf_busy_cycles = busy_cnt_reg;
  assign perf_wait_cycles = wait_cnt_reg;
`endif

endmodule
